// File: rtl/mac_tile_seq.sv
// mac_tile_seq: per-tile weight load, activation stream and drain sequencer
// for the ROW x COLUMN systolic mac array. Optional bias: MAC_TILE_SEQ_BIAS_EN.
// Ports: clk, rst (sync, active high), start, cfg_vec_num, cfg_tile_num,
//  busy, done, tile_idx; w_s_* weight stream in; x_s_* activation stream in;
//  [b_s_* bias stream in]; w, w_en, ci, mac_m_* to the array.
module mac_tile_seq #(
  parameter int DW     = 8,
  parameter int WW     = 8,
  parameter int CW     = 19,
  parameter int ROW    = 8,
  parameter int COLUMN = 6,
  parameter int LAT    = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [15:0]          cfg_vec_num,
  input  logic [7:0]           cfg_tile_num,
  output logic                 busy,
  output logic                 done,
  output logic [7:0]           tile_idx,
  input  logic [COLUMN*WW-1:0] w_s_data,
  input  logic                 w_s_valid,
  output logic                 w_s_ready,
  input  logic [ROW*DW-1:0]    x_s_data,
  input  logic                 x_s_valid,
  output logic                 x_s_ready,
`ifdef MAC_TILE_SEQ_BIAS_EN
  input  logic [COLUMN*CW-1:0] b_s_data,
  input  logic                 b_s_valid,
  output logic                 b_s_ready,
`endif
  output logic [COLUMN*WW-1:0] w,
  output logic                 w_en,
  output logic [COLUMN*CW-1:0] ci,
  output logic [ROW*DW-1:0]    mac_m_data,
  output logic                 mac_m_first,
  output logic                 mac_m_last,
  output logic                 mac_m_valid,
  input  logic                 mac_m_ready
);

  typedef enum logic [2:0] {
    IDLE, WFILL, WBURST, STREAM, DRAIN, DONE
  } state_t;

  localparam int FW  = $clog2(ROW + 1);
  localparam int BW  = $clog2(ROW);
  localparam int DCW = $clog2(LAT);
  localparam logic [FW-1:0]  FILL_FULL  = FW'(ROW);
  localparam logic [BW-1:0]  BURST_END  = BW'(ROW - 1);
  localparam logic [DCW-1:0] DRAIN_INIT = DCW'(LAT - 1);

  state_t state, state_n;
  logic [FW-1:0]  fill;
  logic [BW-1:0]  bcnt;
  logic [DCW-1:0] dcnt;
  logic [15:0]    beat;
  logic [15:0]    vec_num;
  logic [7:0]     tiles;
  logic [COLUMN*WW-1:0] wbuf [ROW];
  logic w_acc, x_fire, beat_last;
  logic w_full, b_full, tile_last, tile_end;

`ifdef MAC_TILE_SEQ_BIAS_EN
  logic [COLUMN*CW-1:0] bias;
  logic                 bias_got;
  assign b_s_ready = (state == WFILL) && !bias_got;
  assign b_full    = bias_got;
  assign ci        = (state == STREAM) ? bias : '0;
`else
  assign b_full = 1'b1;
  assign ci     = '0;
`endif

  assign w_full    = (fill == FILL_FULL);
  assign w_s_ready = (state == WFILL) && !w_full;
  assign w_acc     = w_s_valid && w_s_ready;
  assign x_fire    = (state == STREAM) && x_s_valid && mac_m_ready;
  assign beat_last = (beat == vec_num - 16'd1);
  assign tile_last = (tile_idx == tiles - 8'd1);
  assign tile_end  = (state == DRAIN) && (dcnt == '0);

  assign busy = (state != IDLE) && (state != DONE);
  assign done = (state == DONE);

  // One w_en pulse; the array skews it so row k latches cycle k's word.
  assign w    = (state == WBURST) ? wbuf[bcnt] : '0;
  assign w_en = (state == WBURST) && (bcnt == '0);

  assign mac_m_valid = (state == STREAM) && x_s_valid;
  assign x_s_ready   = (state == STREAM) && mac_m_ready;
  assign mac_m_data  = (state == STREAM) ? x_s_data : '0;
  assign mac_m_first = mac_m_valid && (beat == 16'd0);
  assign mac_m_last  = mac_m_valid && beat_last;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:   if (start) state_n = WFILL;
      WFILL:  if (w_full && b_full) state_n = WBURST;
      WBURST: if (bcnt == BURST_END) state_n = STREAM;
      STREAM: if (x_fire && beat_last) state_n = DRAIN;
      DRAIN:  if (dcnt == '0) state_n = tile_last ? DONE : WFILL;
      DONE:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      fill     <= '0;
      bcnt     <= '0;
      dcnt     <= DRAIN_INIT;
      beat     <= '0;
      vec_num  <= 16'd1;
      tiles    <= 8'd1;
      tile_idx <= '0;
`ifdef MAC_TILE_SEQ_BIAS_EN
      bias     <= '0;
      bias_got <= 1'b0;
`endif
    end else begin
      state <= state_n;
      bcnt  <= (state == WBURST) ? bcnt + 1'b1 : '0;
      dcnt  <= (state == DRAIN) ? dcnt - 1'b1 : DRAIN_INIT;
      if (state != STREAM)
        beat <= '0;
      else if (x_fire)
        beat <= beat + 16'd1;
      if (w_acc)
        fill <= fill + 1'b1;
      if ((state == IDLE) && start) begin
        vec_num  <= (cfg_vec_num == 16'd0) ? 16'd1 : cfg_vec_num;
        tiles    <= (cfg_tile_num == 8'd0) ? 8'd1 : cfg_tile_num;
        tile_idx <= '0;
        fill     <= '0;
      end
      if (tile_end) begin
        fill <= '0;
        if (!tile_last)
          tile_idx <= tile_idx + 8'd1;
      end
`ifdef MAC_TILE_SEQ_BIAS_EN
      if (b_s_valid && b_s_ready) begin
        bias     <= b_s_data;
        bias_got <= 1'b1;
      end
      if (((state == IDLE) && start) || tile_end)
        bias_got <= 1'b0;
`endif
    end
  end

  // Buffer needs no reset: fill count restarts on every job and tile.
  always_ff @(posedge clk) begin
    if (w_acc)
      wbuf[fill[BW-1:0]] <= w_s_data;
  end

endmodule

// File: tb/tb_mac_tile_seq.sv
// tb_mac_tile_seq: directed, table-driven bench for mac_tile_seq.
// Drives inputs at posedge+1, samples outputs on the falling edge.
`timescale 1ns/1ps
module tb_mac_tile_seq;
  localparam int DW = 8, WW = 8, CW = 19;
  localparam int ROW = 8, COLUMN = 6, LAT = 10;

  logic clk = 1'b0;
  logic rst, start;
  logic [15:0] cfg_vec_num;
  logic [7:0] cfg_tile_num;
  logic busy, done;
  logic [7:0] tile_idx;
  logic [COLUMN*WW-1:0] w_s_data;
  logic w_s_valid, w_s_ready;
  logic [ROW*DW-1:0] x_s_data;
  logic x_s_valid, x_s_ready;
  logic [COLUMN*WW-1:0] w;
  logic w_en;
  logic [COLUMN*CW-1:0] ci;
  logic [ROW*DW-1:0] mac_m_data;
  logic mac_m_first, mac_m_last, mac_m_valid, mac_m_ready;
`ifdef MAC_TILE_SEQ_BIAS_EN
  localparam logic [COLUMN*CW-1:0] BIAS = {COLUMN{19'h00010}};
  logic [COLUMN*CW-1:0] b_s_data;
  logic b_s_valid, b_s_ready;
`endif

  mac_tile_seq #(
    .DW(DW), .WW(WW), .CW(CW), .ROW(ROW), .COLUMN(COLUMN), .LAT(LAT)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_vec_num(cfg_vec_num), .cfg_tile_num(cfg_tile_num),
    .busy(busy), .done(done), .tile_idx(tile_idx),
    .w_s_data(w_s_data), .w_s_valid(w_s_valid), .w_s_ready(w_s_ready),
    .x_s_data(x_s_data), .x_s_valid(x_s_valid), .x_s_ready(x_s_ready),
`ifdef MAC_TILE_SEQ_BIAS_EN
    .b_s_data(b_s_data), .b_s_valid(b_s_valid), .b_s_ready(b_s_ready),
`endif
    .w(w), .w_en(w_en), .ci(ci),
    .mac_m_data(mac_m_data), .mac_m_first(mac_m_first),
    .mac_m_last(mac_m_last), .mac_m_valid(mac_m_valid),
    .mac_m_ready(mac_m_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int vn; int tn; bit gap; bit stall;
    int evn; int etiles; int ebeats;
  } vec_t;
  vec_t tbl [7];

  int errors = 0, checks = 0;
  int cyc = 0, wk = 0;
  bit wgap = 0, stall_en = 0;
  int stall_left = 0;
  bit w_hs = 0;
  int wen_cnt, beats, first_cnt, last_cnt, done_cnt;
  int w_bad, whs_bad, first_bad, last_bad, pass_bad;
  int ci_bad, tile_bad, busy_bad, xr_bad;
  int bpos = ROW, whs_tile = 0, tbeat = 0, exp_vn = 1;
  int last_cyc, done_cyc;
  logic [COLUMN*CW-1:0] exp_ci;

  function automatic logic [COLUMN*WW-1:0] wword(input int k);
    logic [7:0] b;
    b = 8'(k + 1);
    return {COLUMN{b}};
  endfunction

  task automatic check(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_idle(input string p);
    check({p, "_busy"}, 128'(busy), 0);
    check({p, "_done"}, 128'(done), 0);
    check({p, "_w_en"}, 128'(w_en), 0);
    check({p, "_valid"}, 128'(mac_m_valid), 0);
    check({p, "_first"}, 128'(mac_m_first), 0);
    check({p, "_last"}, 128'(mac_m_last), 0);
    check({p, "_w_rdy"}, 128'(w_s_ready), 0);
    check({p, "_x_rdy"}, 128'(x_s_ready), 0);
    check({p, "_w"}, 128'(w), 0);
    check({p, "_ci"}, 128'(ci), 0);
    check({p, "_tile"}, 128'(tile_idx), 0);
  endtask

  // Input driver: weight words k%ROW+1, optional valid gaps, ready stall.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (w_hs) wk++;
      w_s_data = wword(wk % ROW);
      w_s_valid = wgap ? ~w_s_valid : 1'b1;
      x_s_data = {ROW{8'(cyc)}};
      if (stall_en && tbeat == 2 && stall_left > 0) begin
        mac_m_ready = 1'b0;
        stall_left--;
      end else begin
        mac_m_ready = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    w_hs = w_s_valid && w_s_ready;
    if (!rst) begin
      if (w_hs) whs_tile++;
      if (w_en) begin
        wen_cnt++;
        if (whs_tile != ROW) whs_bad++;
        whs_tile = 0;
        bpos = 0;
        tbeat = 0;
      end else if (bpos < ROW) begin
        bpos++;
      end
      if (bpos < ROW) begin
        if (w !== wword(bpos)) w_bad++;
      end else if (w !== '0) begin
        w_bad++;
      end
      exp_ci = '0;
`ifdef MAC_TILE_SEQ_BIAS_EN
      if (mac_m_valid) exp_ci = BIAS;
`endif
      if (ci !== exp_ci) ci_bad++;
      if (mac_m_valid) begin
        if (mac_m_data !== x_s_data || x_s_ready !== mac_m_ready)
          pass_bad++;
        if (mac_m_first !== (tbeat == 0)) first_bad++;
        if (mac_m_last !== (tbeat == exp_vn - 1)) last_bad++;
        if (int'(tile_idx) != wen_cnt - 1) tile_bad++;
        if (mac_m_ready) begin
          beats++;
          if (mac_m_first) first_cnt++;
          if (mac_m_last) begin
            last_cnt++;
            last_cyc = cyc;
          end
          tbeat++;
        end
      end else if (mac_m_first || mac_m_last) begin
        first_bad++;
      end
      if (!mac_m_ready && x_s_ready) xr_bad++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        if (busy) busy_bad++;
      end
    end
  end

  task automatic start_job(input vec_t v);
    @(negedge clk);
    #1;
    wk = 0; wgap = v.gap; stall_en = v.stall; stall_left = 3;
    wen_cnt = 0; beats = 0; first_cnt = 0; last_cnt = 0;
    done_cnt = 0; w_bad = 0; whs_bad = 0; first_bad = 0;
    last_bad = 0; pass_bad = 0; ci_bad = 0; tile_bad = 0;
    busy_bad = 0; xr_bad = 0; bpos = ROW; whs_tile = 0;
    tbeat = 0; exp_vn = v.evn; last_cyc = 0; done_cyc = 0;
    start = 1'b1;
    cfg_vec_num = 16'(v.vn);
    cfg_tile_num = 8'(v.tn);
    @(negedge clk);
    #1;
    start = 1'b0;
    cfg_vec_num = 16'd99;
    cfg_tile_num = 8'd7;
  endtask

  task automatic run_job(input int id, input vec_t v);
    string p;
    int n;
    p = $sformatf("v%0d", id);
    start_job(v);
    check({p, "_busy_run"}, 128'(busy), 1);
    n = 0;
    while (done_cnt == 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    check({p, "_timeout"}, 128'(done_cnt != 0), 1);
    repeat (3) @(negedge clk);
    #1;
    check({p, "_beats"}, 128'(beats), 128'(v.ebeats));
    check({p, "_w_en_cnt"}, 128'(wen_cnt), 128'(v.etiles));
    check({p, "_first_cnt"}, 128'(first_cnt), 128'(v.etiles));
    check({p, "_last_cnt"}, 128'(last_cnt), 128'(v.etiles));
    check({p, "_done_cnt"}, 128'(done_cnt), 1);
    check({p, "_w_seq"}, 128'(w_bad), 0);
    check({p, "_fill_8"}, 128'(whs_bad), 0);
    check({p, "_first"}, 128'(first_bad), 0);
    check({p, "_last"}, 128'(last_bad), 0);
    check({p, "_pass"}, 128'(pass_bad), 0);
    check({p, "_ci"}, 128'(ci_bad), 0);
    check({p, "_tile_idx"}, 128'(tile_bad), 0);
    check({p, "_busy_done"}, 128'(busy_bad), 0);
    check({p, "_x_rdy"}, 128'(xr_bad), 0);
    check({p, "_drain"}, 128'(done_cyc - last_cyc), 128'(LAT + 1));
    check({p, "_tile_hold"}, 128'(tile_idx), 128'(v.etiles - 1));
    check({p, "_idle"}, 128'(busy), 0);
  endtask

  initial begin
    vec_t t1;
    int n;
    rst = 1'b1; start = 1'b0;
    cfg_vec_num = '0; cfg_tile_num = '0;
    w_s_data = '0; w_s_valid = 1'b0;
    x_s_data = '0; x_s_valid = 1'b1;
    mac_m_ready = 1'b1;
`ifdef MAC_TILE_SEQ_BIAS_EN
    b_s_data = BIAS;
    b_s_valid = 1'b1;
`endif
    tbl[0] = '{4, 1, 0, 0, 4, 1, 4};
    tbl[1] = '{4, 1, 1, 0, 4, 1, 4};
    tbl[2] = '{6, 1, 0, 1, 6, 1, 6};
    tbl[3] = '{0, 3, 0, 0, 1, 3, 3};
    tbl[4] = '{2, 0, 1, 0, 2, 1, 2};
    tbl[5] = '{1, 2, 0, 0, 1, 2, 2};
    tbl[6] = '{3, 2, 1, 1, 3, 2, 6};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle("rst0");
    #1;
    rst = 1'b0;

    t1 = '{8, 2, 0, 0, 8, 2, 16};
    start_job(t1);
    n = 0;
    while (beats < 2 && n < 500) begin
      @(posedge clk);
      n++;
    end
    check("t1_stream", 128'(beats >= 2), 1);
    @(negedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_idle($sformatf("t1_rst%0d", i));
    end
    #1;
    rst = 1'b0;

    for (int i = 0; i < 7; i++)
      run_job(i, tbl[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
